sdram_req_bridge: RTL
=====================

Name: sdram_req_bridge

Overview:
Multi-client front end for one toggle-handshake SDRAM controller port. It generalises the single-CPU edge/address-change request generator to NCH byte-wide clients with parametrised address width. Features:
- round-robin arbitration
- proper request/acknowledge completion tracking
- one-deep per-client request queue
- busy flags toward clients
- watchdog timeout

It sits between emulated-machine buses (CPU, FDC, video fetch) and the sdram module, all in the SDRAM clock domain.

Parameters:
NCH, 2, number of client channels (1..8)
AW, 16, client byte-address width; SDRAM word address is AW-1 bits
RETRIG, 1, 1 = address change while cs&oe held issues a new read; 0 = only oe/we rising edges trigger
TIMEOUT, 255, max cycles waiting for ack before abandoning (8-bit counter; 0 disables)

Ports:
clk_sys  in  1  SDRAM-domain clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
cli_cs  in  NCH  per-client chip select
cli_oe  in  NCH  per-client read enable
cli_we  in  NCH  per-client write enable (we has priority if oe and we both high)
cli_a  in  NCH*AW  per-client byte address, client i at [i*AW +: AW]
cli_d  in  NCH*8  per-client write data
cli_q  out  NCH*8  per-client last read byte, held until next read completes
cli_busy  out  NCH  client request pending or in flight
cli_err  out  NCH  one-cycle pulse: client request abandoned on timeout
sd_req  out  1  toggle request to controller
sd_ack  in  1  toggle acknowledge; transaction complete when sd_ack == sd_req
sd_a  out  AW-1  word address = latched a[AW-1:1]
sd_ds  out  2  byte lanes: write a[0]=1 -> 2'b10, a[0]=0 -> 2'b01; read 2'b11
sd_we  out  1  write strobe for current transaction
sd_d  out  16  {d,d} of current write
sd_q  in  16  read data, valid when sd_ack == sd_req

Behaviour:
- Reset (async, reset_n low): sd_req=0, sd_a=0, sd_ds=2'b11, sd_we=0, sd_d=0, all cli_q=0, cli_busy=0, cli_err=0, pending/queued flags clear, rr pointer=0, FSM=SYNC.
- Trigger detect per client, registered previous values of cs&oe, cs&we, a. A trigger fires on:
  - rising edge of cs&we
  - rising edge of cs&oe
  - if RETRIG, cs&oe high and a != previous a
- On trigger, the client's request (a, d, we) is latched into a slot.
- Slot rules:
  - If the slot is free, it is filled.
  - If the slot is pending but not yet issued, the slot is overwritten (latest wins).
  - If the client's slot is in flight, the request goes to a one-deep queue; a further trigger overwrites the queue.
  - On completion, the queue moves to the slot in the same cycle.
- cli_busy[i] rises the cycle after the trigger and falls the cycle after completion, unless the queue is non-empty.
- FSM:
  - SYNC: wait until sd_ack == sd_req (covers a controller reset out of step), then IDLE.
  - IDLE: if any slot is pending, pick the first pending client at or after rr pointer (wrapping NCH-1 -> 0). Drive sd_a/sd_ds/sd_we/sd_d from that slot and toggle sd_req in the same cycle, then go to WAIT. Zero-cycle re-arbitration is not required; one IDLE cycle between transactions.
  - WAIT: when sd_ack == sd_req:
    - for a read, cli_q[i] <= a[0] ? sd_q[15:8] : sd_q[7:0]
    - clear the slot, rr pointer <= i+1 mod NCH, go to IDLE
    - sd_a/sd_ds/sd_we/sd_d stay stable throughout WAIT.
  - Timeout (TIMEOUT != 0): after TIMEOUT cycles in WAIT without ack:
    - pulse cli_err[i] and clear the slot; cli_q is unchanged
    - go to SYNC (sd_req is not re-toggled; a late ack realigns)
- Simultaneous events:
  - A trigger on a client in the completion cycle is queued if the slot was in flight, otherwise fills the freed slot.
  - Triggers on several clients in one cycle are all latched.
- Latency: trigger-to-sd_req toggle is 2 cycles when idle (detect register + IDLE). Completion to cli_q valid is 1 cycle.
- Deasserting cs/oe/we does not cancel a pending or in-flight request.
- Reset mid-transaction: all state is dropped immediately; after release, SYNC waits for the controller ack to match sd_req=0.

Test Plan:
- Single read, NCH=2, client0 a=16'h1235 oe rising, controller acks after 5 cycles with sd_q=16'hAB12 -> sd_a=15'h091A, sd_ds=2'b11, sd_we=0, sd_req toggled exactly once; cli_q[0]=8'hAB; busy high 7 cycles.
- Write lanes: client1 writes 8'h5A to a=16'h0010, then 8'hC3 to a=16'h0011 -> sd_ds 2'b01 then 2'b10, sd_d 16'h5A5A then 16'hC3C3, sd_we=1, two toggles.
- Arbitration: both clients trigger reads in the same cycle with rr=0 -> client0 served first, then client1; repeat with rr=1 -> client1 first; no client starves over 100 random back-to-back triggers.
- Queue/overwrite: RETRIG=1, client0 holds oe and steps a 0x100 -> 0x102 -> 0x104 while the first read is in flight -> exactly two SDRAM reads (0x080 then 0x082 word addresses); the 0x102 request is overwritten.
- Timeout: TIMEOUT=8, controller never acks -> cli_err[0] one-cycle pulse at WAIT cycle 8, FSM in SYNC; late ack toggle -> IDLE, and the next request proceeds normally.
- Async reset: assert reset_n low mid-WAIT -> all outputs reach reset values without a clock edge; after release with sd_ack=0, the next trigger issues normally.

Source files
------------

// File: rtl/sdram_req_bridge.sv
// Multi-client front end for a toggle-handshake SDRAM controller port: per-client
// trigger detect, pending slot plus one-deep queue, round-robin issue, ack/timeout tracking.
module sdram_req_bridge #(
  parameter int NCH     = 2,
  parameter int AW      = 16,
  parameter bit RETRIG  = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [NCH-1:0]    cli_cs,
  input  logic [NCH-1:0]    cli_oe,
  input  logic [NCH-1:0]    cli_we,
  input  logic [NCH*AW-1:0] cli_a,
  input  logic [NCH*8-1:0]  cli_d,
  output logic [NCH*8-1:0]  cli_q,
  output logic [NCH-1:0]    cli_busy,
  output logic [NCH-1:0]    cli_err,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic [AW-2:0]     sd_a,
  output logic [1:0]        sd_ds,
  output logic              sd_we,
  output logic [15:0]       sd_d,
  input  logic [15:0]       sd_q
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {SYNC, IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     rr_q, rr_d, cur_q, cur_d, pick, nxt;
  logic [7:0]        tmr_q, tmr_d;
  logic              sd_req_q, sd_req_d, sd_we_q, sd_we_d;
  logic [AW-2:0]     sd_a_q, sd_a_d;
  logic [1:0]        sd_ds_q, sd_ds_d;
  logic [15:0]       sd_d_q, sd_d_d;
  logic [NCH*8-1:0]  rdat_q, rdat_d;
  logic [NCH-1:0]    err_q, err_d;

  logic [NCH-1:0]    oe_prev_q, we_prev_q, rd_now, wr_now, trig;
  logic [NCH*AW-1:0] a_prev_q;

  logic [NCH-1:0]    slot_vld_q, slot_vld_d, slot_we_q, slot_we_d;
  logic [NCH*AW-1:0] slot_a_q, slot_a_d;
  logic [NCH*8-1:0]  slot_dat_q, slot_dat_d;
  logic [NCH-1:0]    qv_q, qv_d, q_we_q, q_we_d;
  logic [NCH*AW-1:0] q_a_q, q_a_d;
  logic [NCH*8-1:0]  q_dat_q, q_dat_d;

  logic              fin;
  logic              found;
  logic [AW-1:0]     pick_a;
  logic              cur_a0;

  assign rd_now = cli_cs & cli_oe;
  assign wr_now = cli_cs & cli_we;

  // Address retrigger applies only to held reads; a held write never re-issues.
  always_comb begin
    trig = '0;
    for (int i = 0; i < NCH; i++) begin
      trig[i] = (wr_now[i] & ~we_prev_q[i]) | (rd_now[i] & ~oe_prev_q[i]) |
                (RETRIG & rd_now[i] & ~wr_now[i] &
                 (cli_a[i*AW +: AW] != a_prev_q[i*AW +: AW]));
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    for (int k = 0; k < NCH; k++) begin
      if (!found && slot_vld_q[(int'(rr_q) + k) % NCH]) begin
        found = 1'b1;
        pick  = CW'((int'(rr_q) + k) % NCH);
      end
    end
  end

  assign pick_a = slot_a_q[int'(pick)*AW +: AW];
  assign cur_a0 = slot_a_q[int'(cur_q)*AW];
  assign nxt    = (cur_q == CW'(NCH - 1)) ? '0 : cur_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cur_d    = cur_q;
    tmr_d    = tmr_q;
    sd_req_d = sd_req_q;
    sd_a_d   = sd_a_q;
    sd_ds_d  = sd_ds_q;
    sd_we_d  = sd_we_q;
    sd_d_d   = sd_d_q;
    rdat_d   = rdat_q;
    err_d    = '0;
    fin      = 1'b0;
    case (state_q)
      SYNC: if (sd_ack == sd_req_q) state_d = IDLE;
      IDLE: if (found) begin
        cur_d    = pick;
        tmr_d    = '0;
        sd_req_d = ~sd_req_q;
        sd_a_d   = pick_a[AW-1:1];
        sd_we_d  = slot_we_q[pick];
        sd_ds_d  = slot_we_q[pick] ? (pick_a[0] ? 2'b10 : 2'b01) : 2'b11;
        sd_d_d   = {2{slot_dat_q[int'(pick)*8 +: 8]}};
        state_d  = WAIT;
      end
      WAIT: if (sd_ack == sd_req_q) begin
        fin = 1'b1;
        if (!sd_we_q) rdat_d[int'(cur_q)*8 +: 8] = cur_a0 ? sd_q[15:8] : sd_q[7:0];
        rr_d    = nxt;
        state_d = IDLE;
      end else if (TIMEOUT != 0 && tmr_q == 8'(TIMEOUT - 1)) begin
        // Abandon without re-toggling sd_req; SYNC absorbs the late ack.
        fin          = 1'b1;
        err_d[cur_q] = 1'b1;
        rr_d         = nxt;
        state_d      = SYNC;
      end else begin
        tmr_d = tmr_q + 8'd1;
      end
      default: state_d = SYNC;
    endcase
  end

  // A client is in flight from its issue cycle until release; triggers then go to the queue.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_we_d  = slot_we_q;
    slot_a_d   = slot_a_q;
    slot_dat_d = slot_dat_q;
    qv_d       = qv_q;
    q_we_d     = q_we_q;
    q_a_d      = q_a_q;
    q_dat_d    = q_dat_q;
    for (int i = 0; i < NCH; i++) begin
      if (fin && int'(cur_q) == i) begin
        slot_vld_d[i]           = qv_q[i];
        slot_we_d[i]            = q_we_q[i];
        slot_a_d[i*AW +: AW]    = q_a_q[i*AW +: AW];
        slot_dat_d[i*8 +: 8]    = q_dat_q[i*8 +: 8];
        qv_d[i]                 = 1'b0;
        if (trig[i] && qv_q[i]) begin
          qv_d[i]               = 1'b1;
          q_we_d[i]             = wr_now[i];
          q_a_d[i*AW +: AW]     = cli_a[i*AW +: AW];
          q_dat_d[i*8 +: 8]     = cli_d[i*8 +: 8];
        end else if (trig[i]) begin
          slot_vld_d[i]         = 1'b1;
          slot_we_d[i]          = wr_now[i];
          slot_a_d[i*AW +: AW]  = cli_a[i*AW +: AW];
          slot_dat_d[i*8 +: 8]  = cli_d[i*8 +: 8];
        end
      end else if (trig[i]) begin
        if ((state_q == WAIT && int'(cur_q) == i) ||
            (state_q == IDLE && found && int'(pick) == i)) begin
          qv_d[i]               = 1'b1;
          q_we_d[i]             = wr_now[i];
          q_a_d[i*AW +: AW]     = cli_a[i*AW +: AW];
          q_dat_d[i*8 +: 8]     = cli_d[i*8 +: 8];
        end else begin
          slot_vld_d[i]         = 1'b1;
          slot_we_d[i]          = wr_now[i];
          slot_a_d[i*AW +: AW]  = cli_a[i*AW +: AW];
          slot_dat_d[i*8 +: 8]  = cli_d[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SYNC;
      rr_q       <= '0;
      cur_q      <= '0;
      tmr_q      <= '0;
      sd_req_q   <= 1'b0;
      sd_a_q     <= '0;
      sd_ds_q    <= 2'b11;
      sd_we_q    <= 1'b0;
      sd_d_q     <= '0;
      rdat_q     <= '0;
      err_q      <= '0;
      oe_prev_q  <= '0;
      we_prev_q  <= '0;
      a_prev_q   <= '0;
      slot_vld_q <= '0;
      qv_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cur_q      <= cur_d;
      tmr_q      <= tmr_d;
      sd_req_q   <= sd_req_d;
      sd_a_q     <= sd_a_d;
      sd_ds_q    <= sd_ds_d;
      sd_we_q    <= sd_we_d;
      sd_d_q     <= sd_d_d;
      rdat_q     <= rdat_d;
      err_q      <= err_d;
      oe_prev_q  <= rd_now;
      we_prev_q  <= wr_now;
      a_prev_q   <= cli_a;
      slot_vld_q <= slot_vld_d;
      qv_q       <= qv_d;
    end
  end

  // Request payloads are qualified by the valid flags and need no reset.
  always_ff @(posedge clk_sys) begin
    slot_we_q  <= slot_we_d;
    slot_a_q   <= slot_a_d;
    slot_dat_q <= slot_dat_d;
    q_we_q     <= q_we_d;
    q_a_q      <= q_a_d;
    q_dat_q    <= q_dat_d;
  end

  assign sd_req   = sd_req_q;
  assign sd_a     = sd_a_q;
  assign sd_ds    = sd_ds_q;
  assign sd_we    = sd_we_q;
  assign sd_d     = sd_d_q;
  assign cli_q    = rdat_q;
  assign cli_busy = slot_vld_q | qv_q;
  assign cli_err  = err_q;

endmodule
